// File: rtl/soi_trace_pkg.sv
// Shared widths, record layout and helpers for the SOI trace transmitter.
package soi_trace_pkg;

    localparam int SOI_W_D  = 1;
    localparam int TS_W_D   = 32;
    localparam int LOSS_W_D = 8;

    // One trace record at the default widths: observed value, cycle stamp,
    // and how many records were dropped just before this one.
    typedef struct packed {
        logic [SOI_W_D-1:0]  soi;
        logic [TS_W_D-1:0]   ts;
        logic [LOSS_W_D-1:0] lost;
    } soi_rec_t;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/soi_trace_fifo.sv
// Generic synchronous FIFO with a registered head entry. A push into a full
// FIFO is accepted when a pop happens on the same edge.
module soi_trace_fifo
    import soi_trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign level   = count;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage array; only written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + ONE_COUNT;
            end else if (do_pop && !do_push) begin
                count <= count - ONE_COUNT;
            end
        end
    end

    // Head register mirrors the oldest entry so the output is a flop, not a mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
        end else if (do_pop) begin
            if (count > ONE_COUNT) begin
                head <= mem[rd_ptr + AW'(1)];
            end else if (do_push) begin
                head <= din;
            end
        end else if (do_push && empty) begin
            head <= din;
        end
    end

endmodule

// File: rtl/soi_trace_tx.sv
// SOI trace transmitter: detects changes on the observed signal, stamps them
// with the cycle count and streams them out through a small FIFO, counting
// records lost to backpressure.
module soi_trace_tx
    import soi_trace_pkg::*;
#(
    parameter int SOI_W  = SOI_W_D,
    parameter int TS_W   = TS_W_D,
    parameter int DEPTH  = 8,
    parameter int LOSS_W = LOSS_W_D
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [SOI_W-1:0]        soi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SOI_W-1:0]        out_soi,
    output logic [TS_W-1:0]         out_ts,
    output logic [LOSS_W-1:0]       out_lost,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int REC_W = SOI_W + TS_W + LOSS_W;
    localparam logic [31:0] LOST_MAX = 32'((64'd1 << LOSS_W) - 64'd1);

    logic [TS_W-1:0]   ts;
    logic [SOI_W-1:0]  prev;
    logic              primed;
    logic [LOSS_W-1:0] lost_cnt;
    logic              overflow_q;

    logic              cap;
    logic              pop;
    logic              push;
    logic              drop;
    logic              full;
    logic              empty;
    logic [REC_W-1:0]  din;
    logic [REC_W-1:0]  head;

    // A capture is the first enabled cycle or any enabled change of soi.
    assign cap  = en & (~primed | (soi != prev));
    assign pop  = out_valid & out_ready;
    assign push = cap & (~full | pop);
    assign drop = cap & ~push;
    assign din  = {soi, ts, lost_cnt};

    assign out_valid = ~empty;
    assign overflow  = overflow_q;
    assign {out_soi, out_ts, out_lost} = head;

    // Free-running cycle stamp; wraps naturally at 2^TS_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // Change-detect history; primed tracks en so re-enabling records once.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev   <= '0;
            primed <= 1'b0;
        end else begin
            prev   <= soi;
            primed <= en;
        end
    end

    // Drop accounting: a stored record carries and clears the loss count.
    always_ff @(posedge clk) begin
        if (rst) begin
            lost_cnt   <= '0;
            overflow_q <= 1'b0;
        end else if (push) begin
            lost_cnt <= '0;
        end else if (drop) begin
            lost_cnt   <= LOSS_W'(sat_inc(32'(lost_cnt), LOST_MAX));
            overflow_q <= 1'b1;
        end
    end

    soi_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: tb/tb_soi_trace_tx.sv
// Directed bench for soi_trace_tx with a queue scoreboard of expected records.
module tb_soi_trace_tx;
    import soi_trace_pkg::*;

    localparam int SOI_W  = SOI_W_D;
    localparam int TS_W   = TS_W_D;
    localparam int LOSS_W = LOSS_W_D;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [SOI_W-1:0]  soi;
    logic              out_valid;
    logic              out_ready;
    logic [SOI_W-1:0]  out_soi;
    logic [TS_W-1:0]   out_ts;
    logic [LOSS_W-1:0] out_lost;
    logic              overflow;
    logic [LVL_W-1:0]  level;

    soi_trace_tx #(
        .SOI_W  (SOI_W),
        .TS_W   (TS_W),
        .DEPTH  (DEPTH),
        .LOSS_W (LOSS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .soi       (soi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_soi   (out_soi),
        .out_ts    (out_ts),
        .out_lost  (out_lost),
        .overflow  (overflow),
        .level     (level)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int popCount  = 0;
    int maxLost   = 0;

    soi_rec_t          sb[$];
    logic [TS_W-1:0]   mTs;
    logic [SOI_W-1:0]  mPrev;
    logic              mPrimed;
    logic [LOSS_W-1:0] mLost;
    logic              mOvf;
    bit                sinceReset;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare DUT outputs against the scoreboard head and model status.
    task automatic checkOutput();
        checkVal("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        checkVal("level", 64'(level), 64'(sb.size()));
        checkVal("overflow", 64'(overflow), 64'(mOvf));
        if (sb.size() != 0) begin
            checkVal("out_soi", 64'(out_soi), 64'(sb[0].soi));
            checkVal("out_ts", 64'(out_ts), 64'(sb[0].ts));
            checkVal("out_lost", 64'(out_lost), 64'(sb[0].lost));
        end else if (sinceReset) begin
            checkVal("rst_out_soi", 64'(out_soi), 64'd0);
            checkVal("rst_out_ts", 64'(out_ts), 64'd0);
            checkVal("rst_out_lost", 64'(out_lost), 64'd0);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            popCount++;
            if (int'(out_lost) > maxLost) maxLost = int'(out_lost);
        end
    endtask

    // Reference behaviour at one rising edge, using the inputs just applied.
    task automatic modelEdge();
        bit       cap;
        bit       popNow;
        int       sz;
        soi_rec_t r;
        if (rst) begin
            sb.delete();
            mTs        = '0;
            mPrev      = '0;
            mPrimed    = 1'b0;
            mLost      = '0;
            mOvf       = 1'b0;
            sinceReset = 1'b1;
        end else begin
            sz     = sb.size();
            popNow = (sz != 0) && (out_ready == 1'b1);
            cap    = en && (!mPrimed || (soi != mPrev));
            if (popNow) r = sb.pop_front();
            if (cap) begin
                if (sz < DEPTH || popNow) begin
                    r.soi  = soi;
                    r.ts   = mTs;
                    r.lost = mLost;
                    sb.push_back(r);
                    mLost      = '0;
                    sinceReset = 1'b0;
                end else begin
                    if (mLost != '1) mLost = mLost + 1'b1;
                    mOvf = 1'b1;
                end
            end
            mPrev   = soi;
            mPrimed = en;
            mTs     = mTs + 1'b1;
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input logic e, input logic [SOI_W-1:0] s,
                                 input logic r, input logic rs);
        en        = e;
        soi       = s;
        out_ready = r;
        rst       = rs;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // Directed sequence.
    initial begin
        logic [SOI_W-1:0] s;
        rst = 1'b1; en = 1'b0; soi = '0; out_ready = 1'b0;
        s = '0;
        @(posedge clk);
        modelEdge();
        #1;
        applyStimulus(1'b0, s, 1'b0, 1'b1);

        $display("[TB] step 1: initial record on enable");
        popCount = 0;
        applyStimulus(1'b0, s, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, s, 1'b1, 1'b0);
        checkVal("t1_records", 64'(popCount), 64'd1);

        $display("[TB] step 2: toggling soi");
        for (int i = 0; i < 6; i++) begin
            s = ~s;
            applyStimulus(1'b1, s, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, s, 1'b1, 1'b0);
        checkVal("t2_records", 64'(popCount), 64'd7);
        checkVal("t2_overflow", 64'(overflow), 64'd0);

        $display("[TB] step 3: backpressure drops");
        maxLost = 0;
        for (int i = 0; i < 7; i++) begin
            s = ~s;
            applyStimulus(1'b1, s, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, s, 1'b0, 1'b0);
        checkVal("t3_level", 64'(level), 64'd4);
        checkVal("t3_overflow", 64'(overflow), 64'd1);
        applyStimulus(1'b1, s, 1'b1, 1'b0);
        s = ~s;
        applyStimulus(1'b1, s, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, s, 1'b1, 1'b0);
        checkVal("t3_lost", 64'(maxLost), 64'd3);

        $display("[TB] step 4: stall stability and full push+pop");
        for (int i = 0; i < 6; i++) begin
            s = ~s;
            applyStimulus(1'b1, s, 1'b0, 1'b0);
        end
        s = ~s;
        applyStimulus(1'b1, s, 1'b1, 1'b0);
        checkVal("t4_level", 64'(level), 64'd4);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, s, 1'b1, 1'b0);

        $display("[TB] step 5: loss counter saturation");
        maxLost = 0;
        for (int i = 0; i < 304; i++) begin
            s = ~s;
            applyStimulus(1'b1, s, 1'b0, 1'b0);
        end
        s = ~s;
        applyStimulus(1'b1, s, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, s, 1'b1, 1'b0);
        checkVal("t5_lost_sat", 64'(maxLost), 64'd255);

        $display("[TB] step 6: mid-stream reset");
        for (int i = 0; i < 3; i++) begin
            s = ~s;
            applyStimulus(1'b1, s, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, s, 1'b0, 1'b0);
        checkVal("t6_level_pre", 64'(level), 64'd3);
        applyStimulus(1'b0, s, 1'b0, 1'b1);
        checkVal("t6_valid", 64'(out_valid), 64'd0);
        checkVal("t6_level", 64'(level), 64'd0);
        checkVal("t6_overflow", 64'(overflow), 64'd0);
        checkVal("t6_ts", 64'(out_ts), 64'd0);
        applyStimulus(1'b0, s, 1'b1, 1'b0);
        applyStimulus(1'b1, s, 1'b1, 1'b0);
        checkVal("t6_fresh_ts", 64'(out_ts), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, s, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
